mw8080_video_scan: RTL and testbench
====================================

# mw8080_video_scan

Video-side reader of the shared work/video RAM in the Midway 8080 cores. It generates raster timing from a pixel clock-enable and fetches one video-RAM byte every 8 pixels. Each byte is serialized LSB-first to a 1-bit video output. It also produces the mid-screen (RST 1) and end-of-screen (RST 2) interrupt requests for the 8080. It sits beside the CPU memory block and drives the second address/data port of the RAM, so it is the consumer of what the CPU writes.

## Interface
Parameters:
- H_TOTAL, 320: pixels per line; hcnt runs 0..H_TOTAL-1.
- V_TOTAL, 262: lines per frame; vcnt runs 0..V_TOTAL-1.
- VRAM_BASE, 13'h0400: RAM offset of video line 0, column 0.
- IRQ_MID_LINE, 96: line that raises RST 1.
- IRQ_END_LINE, 224: line that raises RST 2.

Ports (one clock; reset is asynchronous and active-low):
- Clock  in  1  system clock.
- Reset_n  in  1  asynchronous, active-low reset.
- Pix_Ce  in  1  pixel enable, one Clock wide; consecutive pulses are at least 2 Clocks apart.
- Vram_Addr  out  13  RAM read address.
- Vram_Data  in  8  RAM read data, valid 1 Clock after Vram_Addr.
- Video  out  1  pixel bit.
- HBlank  out  1  high outside output columns 8..263.
- VBlank  out  1  high outside lines 0..223.
- HSync  out  1  high for hcnt 280..311.
- VSync  out  1  high for vcnt 230..233.
- Irq_Req  out  1  interrupt request.
- Irq_Vec  out  8  RST opcode: 8'hCF (RST 1) or 8'hD7 (RST 2).
- Irq_Ack  in  1  one-Clock acknowledge from the CPU wrapper.

## Operation
- Counters advance only on Pix_Ce. hcnt wraps H_TOTAL-1 -> 0 and increments vcnt. vcnt wraps V_TOTAL-1 -> 0.
- Fetch: on Pix_Ce with hcnt < 256 and hcnt[2:0]==0, register Vram_Addr = VRAM_BASE + {vcnt[7:0],5'b0} + hcnt[7:3]. The maximum is 13'h1FFF at line 223, column 31.
- Fetch only for vcnt < 224. Otherwise Vram_Addr holds its last value.
- Vram_Data is captured into a hold register on the Clock after the address is registered.
- Shifter: on Pix_Ce at hcnt[2:0]==7, load the hold register if the fetch was in a visible line and column; otherwise load 0. On every other Pix_Ce, shift right. Video = shifter[0].
- Byte column c therefore appears on Video at hcnt 8c+8 .. 8c+15, bit 0 first. The pipeline delay is 8 pixels.
- HBlank, VBlank, HSync and VSync are registered on Pix_Ce from the counter values. They are aligned with Video.
- Interrupts: on the Pix_Ce where hcnt wraps into vcnt==IRQ_MID_LINE, set Irq_Req=1 and Irq_Vec=8'hCF. At vcnt==IRQ_END_LINE, set Irq_Vec=8'hD7 instead.
- Irq_Ack clears Irq_Req.
- A new event while a request is pending overwrites Irq_Vec and Irq_Req stays 1.
- If an event and Irq_Ack fall in the same Clock, the event wins: Irq_Req=1 with the new vector.

## Timing
- Reset values:
  - hcnt=0, vcnt=0, Vram_Addr=VRAM_BASE.
  - Hold register and shifter 0, so Video=0.
  - HBlank=1, VBlank=1, HSync=0, VSync=0.
  - Irq_Req=0, Irq_Vec=8'h00.
- Reset deassertion mid-frame restarts at hcnt=0, vcnt=0. No interrupt is generated for the lines that were skipped.
- Pix_Ce held low freezes every output, including Irq_Req. The exceptions are Irq_Ack clearing Irq_Req and the data hold register.
- The frame is 83840 Pix_Ce. Two interrupts fire per frame, 128 lines apart (RST 1 to RST 2) and 134 lines apart (RST 2 to RST 1).

## Structure
- Package mw8080_video_pkg holds H_TOTAL/V_TOTAL defaults, the sync and blank start/end constants, RST1_OPC=8'hCF and RST2_OPC=8'hD7.
- Sub-module mw8080_video_timing contains the hcnt/vcnt counters plus sync and blank decode. The top level adds fetch, shifter and interrupt logic.

## Test plan
- Reset and counting: release reset, apply 320 Pix_Ce -> hcnt back to 0, vcnt=1. Before the first Pix_Ce, outputs equal their reset values.
- Addressing: RAM model returns addr[7:0]. At vcnt=5, the column-3 fetch drives Vram_Addr=13'h04A3.
- Serialization: line 0 column 0 holds 8'b0000_0101 -> Video = 1,0,1,0,0,0,0,0 at hcnt 8..15. Video=0 at hcnt 264..319.
- Blank and sync: over one frame, HSync is high for exactly 32 pixels per line. VSync is high on lines 230..233. VBlank is high on lines 224..261.
- Interrupts: on reaching line 96, Irq_Req=1 with Irq_Vec=CF. Ack -> Irq_Req=0. At line 224, Irq_Vec=D7. An event coincident with Ack leaves Irq_Req=1.
- Reset mid-frame at vcnt=150, hcnt=77: after release, Video=0, counters restart at 0, and the next interrupt is CF at line 96.

Source files
------------

// File: rtl/mw8080_video_scan_pkg.sv
// Midway 8080 video scan: shared raster constants and types.
// Counter widths cover a 320x262 raster.
package mw8080_video_pkg;

  localparam int H_TOTAL_DEF = 320;
  localparam int V_TOTAL_DEF = 262;

  typedef logic [8:0] cnt_t;

  localparam cnt_t H_VIS_START = 9'd8;
  localparam cnt_t H_VIS_END   = 9'd264;
  localparam cnt_t HSYNC_START = 9'd280;
  localparam cnt_t HSYNC_END   = 9'd312;
  localparam cnt_t V_VIS_END   = 9'd224;
  localparam cnt_t VSYNC_START = 9'd230;
  localparam cnt_t VSYNC_END   = 9'd234;
  localparam cnt_t FETCH_END   = 9'd256;

  localparam logic [7:0] RST1_OPC = 8'hCF;
  localparam logic [7:0] RST2_OPC = 8'hD7;

  typedef struct packed {
    logic hblank;
    logic vblank;
    logic hsync;
    logic vsync;
  } sync_t;

  localparam sync_t SYNC_RST = 4'b1100;

  // Half-open window test: lo <= v < hi
  function automatic logic in_win(
    input cnt_t v,
    input cnt_t lo,
    input cnt_t hi
  );
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/mw8080_video_scan_if.sv
// Video-side RAM read port plus the RST interrupt request to the CPU.
// master = scan block, slave = RAM / CPU wrapper.
interface mw8080_video_scan_if;

  logic [12:0] vram_addr;
  logic [7:0]  vram_data;
  logic        irq_req;
  logic [7:0]  irq_vec;
  logic        irq_ack;

  modport master (
    output vram_addr,
    output irq_req,
    output irq_vec,
    input  vram_data,
    input  irq_ack
  );

  modport slave (
    input  vram_addr,
    input  irq_req,
    input  irq_vec,
    output vram_data,
    output irq_ack
  );

endinterface

// File: rtl/mw8080_video_timing.sv
// Raster counters and registered blank/sync decode.
// Decode uses next-count values so outputs line up with Video.
module mw8080_video_timing
  import mw8080_video_pkg::*;
#(
  parameter int H_TOTAL = H_TOTAL_DEF,
  parameter int V_TOTAL = V_TOTAL_DEF
) (
  input  logic  clock,
  input  logic  reset_n,
  input  logic  pix_ce,
  output cnt_t  hcnt,
  output cnt_t  vcnt,
  output cnt_t  vcnt_nxt,
  output logic  eol,
  output sync_t sync
);

  localparam cnt_t H_LAST = cnt_t'(H_TOTAL - 1);
  localparam cnt_t V_LAST = cnt_t'(V_TOTAL - 1);

  cnt_t h_nxt;

  always_comb begin
    eol      = (hcnt == H_LAST);
    h_nxt    = eol ? '0 : hcnt + 9'd1;
    vcnt_nxt = vcnt;
    if (eol) begin
      vcnt_nxt = (vcnt == V_LAST) ? '0 : vcnt + 9'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hcnt <= '0;
      vcnt <= '0;
      sync <= SYNC_RST;
    end else if (pix_ce) begin
      hcnt        <= h_nxt;
      vcnt        <= vcnt_nxt;
      sync.hblank <= !in_win(h_nxt, H_VIS_START, H_VIS_END);
      sync.vblank <= !in_win(vcnt_nxt, '0, V_VIS_END);
      sync.hsync  <= in_win(h_nxt, HSYNC_START, HSYNC_END);
      sync.vsync  <= in_win(vcnt_nxt, VSYNC_START, VSYNC_END);
    end
  end

endmodule

// File: rtl/mw8080_video_scan.sv
// Midway 8080 video scan: VRAM fetch, LSB-first serializer
// and mid/end-of-screen RST interrupt requests.
module mw8080_video_scan
  import mw8080_video_pkg::*;
#(
  parameter int          H_TOTAL      = H_TOTAL_DEF,
  parameter int          V_TOTAL      = V_TOTAL_DEF,
  parameter logic [12:0] VRAM_BASE    = 13'h0400,
  parameter int          IRQ_MID_LINE = 96,
  parameter int          IRQ_END_LINE = 224
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       pix_ce,
  mw8080_video_scan_if.master        bus,
  output logic                       video,
  output logic                       hblank,
  output logic                       vblank,
  output logic                       hsync,
  output logic                       vsync
);

  localparam cnt_t MID_LINE = cnt_t'(IRQ_MID_LINE);
  localparam cnt_t END_LINE = cnt_t'(IRQ_END_LINE);

  cnt_t        hcnt;
  cnt_t        vcnt;
  cnt_t        vcnt_nxt;
  logic        eol;
  sync_t       sync;

  logic [12:0] addr_q;
  logic        fetch_pend;
  logic [7:0]  hold_q;
  logic [7:0]  shift_q;
  logic        req_q;
  logic [7:0]  vec_q;

  logic        vis;
  logic        fetch;
  logic        ev_mid;
  logic        ev_end;
  logic        ack_clr;

  mw8080_video_timing #(
    .H_TOTAL (H_TOTAL),
    .V_TOTAL (V_TOTAL)
  ) u_tim (
    .clock    (clock),
    .reset_n  (reset_n),
    .pix_ce   (pix_ce),
    .hcnt     (hcnt),
    .vcnt     (vcnt),
    .vcnt_nxt (vcnt_nxt),
    .eol      (eol),
    .sync     (sync)
  );

  always_comb begin
    vis     = (hcnt < FETCH_END) && (vcnt < V_VIS_END);
    fetch   = pix_ce && vis && (hcnt[2:0] == 3'd0);
    ev_mid  = pix_ce && eol && (vcnt_nxt == MID_LINE);
    ev_end  = pix_ce && eol && (vcnt_nxt == END_LINE);
    ack_clr = bus.irq_ack && !ev_mid && !ev_end;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      addr_q <= VRAM_BASE;
    end else if (fetch) begin
      addr_q <= VRAM_BASE
              + {vcnt[7:0], 5'b0}
              + {8'b0, hcnt[7:3]};
    end
  end

  // RAM answers one clock after the address; capture regardless of pix_ce
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pend <= 1'b0;
      hold_q     <= '0;
    end else begin
      fetch_pend <= fetch;
      if (fetch_pend) begin
        hold_q <= bus.vram_data;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shift_q <= '0;
    end else if (pix_ce) begin
      if (hcnt[2:0] == 3'd7) begin
        shift_q <= vis ? hold_q : 8'h00;
      end else begin
        shift_q <= {1'b0, shift_q[7:1]};
      end
    end
  end

  // A new event beats a simultaneous acknowledge
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      req_q <= 1'b0;
      vec_q <= 8'h00;
    end else begin
      unique case (1'b1)
        ev_mid: begin
          req_q <= 1'b1;
          vec_q <= RST1_OPC;
        end
        ev_end: begin
          req_q <= 1'b1;
          vec_q <= RST2_OPC;
        end
        ack_clr: begin
          req_q <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.vram_addr = addr_q;
  assign bus.irq_req   = req_q;
  assign bus.irq_vec   = vec_q;

  assign video  = shift_q[0];
  assign hblank = sync.hblank;
  assign vblank = sync.vblank;
  assign hsync  = sync.hsync;
  assign vsync  = sync.vsync;

endmodule

// File: tb/tb_mw8080_video_scan.sv
// Directed bench: full-width raster on dut_a, short-line raster on
// dut_b for frame-level sync, interrupt and mid-frame reset checks.
module tb_mw8080_video_scan;
  import mw8080_video_pkg::*;

  logic clock = 1'b0;
  logic rst_n_a;
  logic rst_n_b;
  logic pix_ce;

  always #5 clock = ~clock;

  mw8080_video_scan_if bus_a ();
  mw8080_video_scan_if bus_b ();

  logic video_a, hblank_a, vblank_a, hsync_a, vsync_a;
  logic video_b, hblank_b, vblank_b, hsync_b, vsync_b;

  function automatic logic [7:0] ram(input logic [12:0] a);
    return (a == 13'h0400) ? 8'h05 : a[7:0];
  endfunction

  assign bus_a.vram_data = ram(bus_a.vram_addr);
  assign bus_a.irq_ack   = 1'b0;
  assign bus_b.vram_data = ram(bus_b.vram_addr);

  mw8080_video_scan dut_a (
    .clock   (clock),
    .reset_n (rst_n_a),
    .pix_ce  (pix_ce),
    .bus     (bus_a),
    .video   (video_a),
    .hblank  (hblank_a),
    .vblank  (vblank_a),
    .hsync   (hsync_a),
    .vsync   (vsync_a)
  );

  mw8080_video_scan #(.H_TOTAL(80)) dut_b (
    .clock   (clock),
    .reset_n (rst_n_b),
    .pix_ce  (pix_ce),
    .bus     (bus_b),
    .video   (video_b),
    .hblank  (hblank_b),
    .vblank  (vblank_b),
    .hsync   (hsync_b),
    .vsync   (vsync_b)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int ha = 0, va = 0, hb = 0, vb = 0;
  int n_steps = 0;
  int phase = 1;
  bit done = 0;
  int ones_a = 0, hs_cnt = 0;
  int vs_lines = 0, vs_bad = 0, vbk_lines = 0, vbk_bad = 0;
  logic [7:0] pat05 = 8'h05;
  logic [7:0] byte_a = 8'h00;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic ack);
    @(negedge clock);
    pix_ce = 1'b1;
    bus_b.irq_ack = ack;
    @(negedge clock);
    pix_ce = 1'b0;
    bus_b.irq_ack = 1'b0;
    if (ha == 319) begin
      ha = 0;
      va = (va == 261) ? 0 : va + 1;
    end else ha++;
    if (hb == 79) begin
      hb = 0;
      vb = (vb == 261) ? 0 : vb + 1;
    end else hb++;
    n_steps++;
  endtask

  task automatic ack_pulse();
    @(negedge clock);
    bus_b.irq_ack = 1'b1;
    @(negedge clock);
    bus_b.irq_ack = 1'b0;
  endtask

  task automatic check_a();
    if (n_steps == 320) begin
      chk("a_hcnt_wrap", dut_a.u_tim.hcnt, 0);
      chk("a_vcnt_wrap", dut_a.u_tim.vcnt, 1);
    end
    if (va == 0 && ha >= 8 && ha <= 15)
      chk("a_ser_col0", video_a, pat05[ha-8]);
    if (va == 0 && ha >= 264 && video_a) ones_a++;
    if (va == 0 && ha == 319) chk("a_tail_zero", ones_a, 0);
    if (va == 1) begin
      if (ha == 7)   chk("a_hblank_7", hblank_a, 1);
      if (ha == 8)   chk("a_hblank_8", hblank_a, 0);
      if (ha == 263) chk("a_hblank_263", hblank_a, 0);
      if (ha == 264) chk("a_hblank_264", hblank_a, 1);
      if (ha == 100) chk("a_vblank_l1", vblank_a, 0);
    end
    if (va == 2) begin
      if (hsync_a) hs_cnt++;
      if (ha == 279) chk("a_hsync_279", hsync_a, 0);
      if (ha == 280) chk("a_hsync_280", hsync_a, 1);
      if (ha == 311) chk("a_hsync_311", hsync_a, 1);
      if (ha == 312) chk("a_hsync_312", hsync_a, 0);
      if (ha == 319) chk("a_hsync_width", hs_cnt, 32);
    end
    if (va == 5) begin
      if (ha == 25) chk("a_addr_l5c3", bus_a.vram_addr, 13'h04A3);
      if (ha >= 32 && ha <= 39) byte_a[ha-32] = video_a;
      if (ha == 39) chk("a_ser_l5c3", byte_a, 8'hA3);
    end
  endtask

  task automatic reset_b();
    @(negedge clock);
    rst_n_b = 1'b0;
    @(negedge clock);
    chk("b_rst_video", video_b, 0);
    chk("b_rst_hblank", hblank_b, 1);
    @(negedge clock);
    rst_n_b = 1'b1;
    @(negedge clock);
    chk("b_rst_hcnt", dut_b.u_tim.hcnt, 0);
    chk("b_rst_vcnt", dut_b.u_tim.vcnt, 0);
    chk("b_rst_vec", bus_b.irq_vec, 8'h00);
    hb = 0;
    vb = 0;
    phase = 2;
  endtask

  task automatic check_b();
    if (vb == 95 && hb == 79) begin
      chk("b_irq_idle", bus_b.irq_req, 0);
      if (phase == 2) chk("b_no_skip_irq", bus_b.irq_vec, 8'h00);
    end
    if (vb == 96 && hb == 0) begin
      chk("b_irq_mid_req", bus_b.irq_req, 1);
      chk("b_irq_mid_vec", bus_b.irq_vec, 8'hCF);
      ack_pulse();
      chk("b_ack_clr", bus_b.irq_req, 0);
      chk("b_ack_vec_hold", bus_b.irq_vec, 8'hCF);
    end
    if (phase == 1 && vb == 150 && hb == 77) begin
      reset_b();
      return;
    end
    if (phase == 2) begin
      if (vb == 224 && hb == 0) begin
        chk("b_irq_end_req", bus_b.irq_req, 1);
        chk("b_irq_end_vec", bus_b.irq_vec, 8'hD7);
        repeat (6) @(negedge clock);
        chk("b_freeze_req", bus_b.irq_req, 1);
      end
      if (hb == 40) begin
        if (vsync_b) vs_lines++;
        if (vblank_b) vbk_lines++;
        if (vsync_b != (vb >= 230 && vb <= 233)) vs_bad++;
        if (vblank_b != (vb >= 224)) vbk_bad++;
      end
      if (vb == 261 && hb == 79) begin
        chk("b_vsync_lines", vs_lines, 4);
        chk("b_vsync_place", vs_bad, 0);
        chk("b_vblank_lines", vbk_lines, 38);
        chk("b_vblank_place", vbk_bad, 0);
        done = 1;
      end
    end
  endtask

  initial begin
    rst_n_a = 1'b0;
    rst_n_b = 1'b0;
    pix_ce = 1'b0;
    bus_b.irq_ack = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_addr", bus_a.vram_addr, 13'h0400);
    chk("rst_video", video_a, 0);
    chk("rst_hblank", hblank_a, 1);
    chk("rst_vblank", vblank_a, 1);
    chk("rst_hsync", hsync_a, 0);
    chk("rst_vsync", vsync_a, 0);
    chk("rst_irq_req", bus_a.irq_req, 0);
    chk("rst_irq_vec", bus_a.irq_vec, 8'h00);
    rst_n_a = 1'b1;
    rst_n_b = 1'b1;
    @(negedge clock);
    chk("rel_video", video_a, 0);
    chk("rel_hblank", hblank_a, 1);
    while (!done && n_steps < 40000) begin
      step(phase == 2 && vb == 223 && hb == 79);
      if (va <= 5) check_a();
      check_b();
    end
    if (!done) chk("timeout", 0, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
